// File: rtl/uart_debug_tx_if.sv
// ============================================================
// uart_debug_tx_if : request handshake between debug source and UART TX
// Rev 1.0
// ============================================================
`default_nettype none

interface uart_debug_tx_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_cmd;
  logic [31:0] req_data;

  modport master (output req_valid, output req_cmd, output req_data, input req_ready);
  modport slave  (input req_valid, input req_cmd, input req_data, output req_ready);
endinterface

`default_nettype wire

// File: rtl/uart_debug_tx.sv
// ============================================================
// uart_debug_tx : serializes one request as a 7-byte 8N1 debug frame with CRC8
// Rev 1.0
// ============================================================
`default_nettype none

module uart_debug_tx #(
  parameter int CLKS_PER_BIT = 100
) (
  input  wire logic        sys_clk,
  input  wire logic        sys_rst_n,
  uart_debug_tx_if.slave   req,
  output logic             busy,
  output logic             uart_tx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [2:0] LAST_BYTE = 3'd6;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [2:0]       byte_q, byte_d;
  logic [7:0]       crc_q, crc_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [31:0]      data_q, data_d;
  logic             uart_tx_q, uart_tx_d;

  logic             bit_end;
  logic [7:0]       crc_rev;
  logic [7:0]       tx_byte;

  assign bit_end = (cnt_q == CNT_MAX);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      crc_q     <= '0;
      cmd_q     <= '0;
      data_q    <= '0;
      uart_tx_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      crc_q     <= crc_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      uart_tx_q <= uart_tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    crc_d   = crc_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    if (state_q != ST_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (req.req_valid) begin
          state_d = ST_START;
          cnt_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
          crc_d   = '0;
          cmd_d   = req.req_cmd;
          data_d  = req.req_data;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        // uart_tx_q already holds the bit on the line during its first cycle
        if ((cnt_q == '0) && (byte_q != LAST_BYTE)) begin
          crc_d = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ uart_tx_q) ? 8'h07 : 8'h00);
        end
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (byte_q < LAST_BYTE) begin
            byte_d  = byte_q + 3'd1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      crc_rev[i] = crc_q[7-i];
    end
    case (byte_d)
      3'd0:    tx_byte = 8'hCD;
      3'd1:    tx_byte = cmd_q;
      3'd2:    tx_byte = data_q[7:0];
      3'd3:    tx_byte = data_q[15:8];
      3'd4:    tx_byte = data_q[23:16];
      3'd5:    tx_byte = data_q[31:24];
      3'd6:    tx_byte = crc_rev;
      default: tx_byte = 8'hFF;
    endcase
    // Line level is derived from the next state so uart_tx stays a pure flop
    uart_tx_d = 1'b1;
    case (state_d)
      ST_START: uart_tx_d = 1'b0;
      ST_DATA:  uart_tx_d = tx_byte[bit_d];
      default:  uart_tx_d = 1'b1;
    endcase
  end

  assign req.req_ready = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign uart_tx       = uart_tx_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_debug_tx.sv
// ============================================================
// tb_uart_debug_tx : directed frame checks on two baud settings (4 and 2)
// Rev 1.0
// ============================================================
`default_nettype none

module tb_uart_debug_tx;

  logic        clk = 1'b0;
  logic [1:0]  rst_n;
  logic [1:0]  v;
  logic [7:0]  cmd_in  [2];
  logic [31:0] data_in [2];
  logic [1:0]  tx_w, busy_w, ready_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_debug_tx_if if0 ();
  uart_debug_tx_if if1 ();

  assign if0.req_valid = v[0];
  assign if0.req_cmd   = cmd_in[0];
  assign if0.req_data  = data_in[0];
  assign if1.req_valid = v[1];
  assign if1.req_cmd   = cmd_in[1];
  assign if1.req_data  = data_in[1];
  assign ready_w[0]    = if0.req_ready;
  assign ready_w[1]    = if1.req_ready;

  uart_debug_tx #(.CLKS_PER_BIT(4)) u_dut4 (
    .sys_clk   (clk),
    .sys_rst_n (rst_n[0]),
    .req       (if0.slave),
    .busy      (busy_w[0]),
    .uart_tx   (tx_w[0])
  );

  uart_debug_tx #(.CLKS_PER_BIT(2)) u_dut2 (
    .sys_clk   (clk),
    .sys_rst_n (rst_n[1]),
    .req       (if1.slave),
    .busy      (busy_w[1]),
    .uart_tx   (tx_w[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[7] ^ b[i];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  // Called at handshake edge + 1; records and decodes one full frame, then the idle cycle
  task automatic capture(input int s, input int c, input logic [7:0] ecmd, input logic [31:0] edata);
    logic       smp [$];
    logic [7:0] exp_b [7];
    logic [7:0] mcrc, rcrc, rx;
    int         werr, berr, ferr;
    werr = 0; berr = 0; ferr = 0;
    exp_b = '{8'hCD, ecmd, edata[7:0], edata[15:8], edata[23:16], edata[31:24], 8'h00};
    mcrc = 8'h00;
    for (int b = 0; b < 6; b++) mcrc = crc8_byte(mcrc, exp_b[b]);
    for (int i = 0; i < 8; i++) exp_b[6][i] = mcrc[7-i];
    for (int i = 0; i < 70*c; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      smp.push_back(tx_w[s]);
      if (busy_w[s] !== 1'b1 || ready_w[s] !== 1'b0) berr++;
      if (i == 35*c) begin
        cmd_in[s]  = 8'($urandom);
        data_in[s] = $urandom;
      end
    end
    check_eq("start_latency", 32'(smp[0]), 32'd0);
    for (int k = 0; k < 70; k++)
      for (int j = 1; j < c; j++)
        if (smp[k*c+j] !== smp[k*c]) werr++;
    rcrc = 8'h00;
    for (int b = 0; b < 7; b++) begin
      if (smp[b*10*c] !== 1'b0) ferr++;
      if (smp[(b*10+9)*c] !== 1'b1) ferr++;
      for (int i = 0; i < 8; i++) rx[i] = smp[(b*10+1+i)*c];
      check_eq($sformatf("byte%0d", b), 32'(rx), 32'(exp_b[b]));
      rcrc = crc8_byte(rcrc, rx);
    end
    check_eq("bit_width_errs", 32'(werr), 32'd0);
    check_eq("framing_errs", 32'(ferr), 32'd0);
    check_eq("busy_during_frame_errs", 32'(berr), 32'd0);
    check_eq("rx_crc_residue", 32'(rcrc), 32'd0);
    @(posedge clk);
    #1;
    check_eq("idle_after_frame", {29'd0, tx_w[s], busy_w[s], ready_w[s]}, 32'b101);
  endtask

  task automatic send(input int s, input int c, input logic [7:0] cmd, input logic [31:0] data);
    @(negedge clk);
    v[s]       = 1'b1;
    cmd_in[s]  = cmd;
    data_in[s] = data;
    @(posedge clk);
    #1;
    v[s] = 1'b0;
    capture(s, c, cmd, data);
  endtask

  logic [7:0]  vec_cmd  [6] = '{8'h02, 8'hFF, 8'hA5, 8'h00, 8'h3C, 8'h81};
  logic [31:0] vec_data [6] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_5678,
                                32'hDEAD_BEEF, 32'h8000_0001, 32'h5A5A_A5A5};

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          idle_err;
    logic [7:0]  bc [3];
    logic [31:0] bd [3];

    rst_n = 2'b00;
    v     = 2'b00;
    for (int s = 0; s < 2; s++) begin
      cmd_in[s]  = 8'h00;
      data_in[s] = 32'h0;
    end
    repeat (5) @(posedge clk);
    #1;
    check_eq("reset_state_dut4", {29'd0, tx_w[0], busy_w[0], ready_w[0]}, 32'b101);
    check_eq("reset_state_dut2", {29'd0, tx_w[1], busy_w[1], ready_w[1]}, 32'b101);
    @(negedge clk);
    rst_n = 2'b11;

    idle_err = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (tx_w !== 2'b11 || busy_w !== 2'b00 || ready_w !== 2'b11) idle_err++;
    end
    check_eq("idle_200_cycles_errs", 32'(idle_err), 32'd0);

    for (int i = 0; i < 6; i++) send(0, 4, vec_cmd[i], vec_data[i]);
    for (int i = 0; i < 6; i++) send(1, 2, vec_cmd[i], vec_data[i]);
    for (int i = 0; i < 4; i++) send(1, 2, 8'($urandom), $urandom);

    // Back-to-back: valid stays high, next request loaded in the single idle cycle
    bc = '{8'h10, 8'h20, 8'h30};
    bd = '{32'h0102_0304, 32'hF0E0_D0C0, 32'h0000_FFFF};
    @(negedge clk);
    v[0]       = 1'b1;
    cmd_in[0]  = bc[0];
    data_in[0] = bd[0];
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) v[0] = 1'b0;
      capture(0, 4, bc[k], bd[k]);
      if (k < 2) begin
        cmd_in[0]  = bc[k+1];
        data_in[0] = bd[k+1];
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("no_extra_frame_busy", 32'(busy_w[0]), 32'd0);

    // Mid-frame reset during byte 3 (data[15:8]=0), data bit 5
    @(negedge clk);
    v[0]       = 1'b1;
    cmd_in[0]  = 8'h11;
    data_in[0] = 32'h0;
    @(posedge clk);
    #1;
    v[0] = 1'b0;
    repeat (36*4 + 2) @(posedge clk);
    #1;
    check_eq("pre_reset_tx_low", 32'(tx_w[0]), 32'd0);
    check_eq("pre_reset_busy", 32'(busy_w[0]), 32'd1);
    rst_n[0] = 1'b0;
    #1;
    check_eq("async_reset_state", {29'd0, tx_w[0], busy_w[0], ready_w[0]}, 32'b101);
    v[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("no_handshake_in_reset", {30'd0, tx_w[0], busy_w[0]}, 32'b10);
    v[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    send(0, 4, 8'h77, 32'hCAFE_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
